// File: rtl/cpu_pio_port.sv
// cpu_pio_port: on-chip processor I/O port for 65xx-class CPU replacements.
// Data register at BASE_ADDR, DDR at BASE_ADDR+1; state changes on the falling
// edge of phi2 (clock). Port pins are synchronised before readback.
// Optional feature macro: FADE_EN. When defined, unbonded port bits are
// stored and their readback decays to 0 FADE_CYCLES falling edges after the
// bit stops being driven as an output, mimicking the floating-pin charge.
module cpu_pio_port #(
  parameter int          WIDTH       = 8,
  parameter logic [7:0]  IMPL_MASK   = 8'hDF,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [7:0]  DATA_RESET  = 8'h00,
  parameter logic [7:0]  DDR_RESET   = 8'h00,
  parameter int          FADE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             _reset,
  input  logic             aec,
  input  logic             r_w,
  input  logic [15:0]      address,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             data_oe,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe
);

  localparam logic [WIDTH-1:0] MASK_W = IMPL_MASK[WIDTH-1:0];
`ifdef FADE_EN
  // Unbonded bits need real storage to drive the fade emulation.
  localparam logic [WIDTH-1:0] STORE_MASK = {WIDTH{1'b1}};
`else
  // Unbonded bits do not exist in silicon; keep them at 0.
  localparam logic [WIDTH-1:0] STORE_MASK = MASK_W;
`endif

  // Elaboration guards on parameter ranges.
  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("cpu_pio_port: WIDTH must be 1..8");
  end
  if (BASE_ADDR[0] != 1'b0) begin : g_bad_base
    $error("cpu_pio_port: BASE_ADDR must be even");
  end
  if (FADE_CYCLES < 1) begin : g_bad_fade
    $error("cpu_pio_port: FADE_CYCLES must be at least 1");
  end

  logic             sel;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] ddr_q;
  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] fade_rd;
  logic [WIDTH-1:0] rd_port;
  logic [7:0]       rd_data;

  assign sel     = aec & (address[15:1] == BASE_ADDR[15:1]);
  // Qualified by phi2 high so the bus is only driven in the data phase.
  assign data_oe = sel & r_w & clock;

  // Register file: data and DDR writes land at the end of phi2.
  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      data_q <= DATA_RESET[WIDTH-1:0] & STORE_MASK;
      ddr_q  <= DDR_RESET[WIDTH-1:0] & STORE_MASK;
    end else if (sel && !r_w) begin
      if (address[0]) ddr_q  <= data_in[WIDTH-1:0] & STORE_MASK;
      else            data_q <= data_in[WIDTH-1:0] & STORE_MASK;
    end
  end

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pio_in;
      sync_q    <= sync_meta;
    end
  end

`ifdef FADE_EN
  localparam int             CW      = $clog2(FADE_CYCLES + 1);
  localparam logic [CW-1:0]  FADE_TC = CW'(FADE_CYCLES);

  for (genvar i = 0; i < WIDTH; i++) begin : g_fade
    if (!MASK_W[i]) begin : g_unbonded
      logic [CW-1:0] cnt_q;
      logic          charge_q;

      // Charge follows the driven value; once released it decays after FADE_CYCLES edges.
      always_ff @(negedge clock or negedge _reset) begin
        if (!_reset) begin
          cnt_q    <= '0;
          charge_q <= 1'b0;
        end else if (ddr_q[i]) begin
          cnt_q    <= '0;
          charge_q <= data_q[i];
        end else if (cnt_q != FADE_TC) begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q + CW'(1) == FADE_TC) charge_q <= 1'b0;
        end
      end

      assign fade_rd[i] = ddr_q[i] ? data_q[i] : charge_q;
    end else begin : g_bonded
      assign fade_rd[i] = 1'b0;
    end
  end
`else
  assign fade_rd = '0;
`endif

  // Readback mux: bonded bits show output latch or synchronised pin, unbonded bits show fade state.
  always_comb begin
    rd_port = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_port[i] = MASK_W[i] ? (ddr_q[i] ? data_q[i] : sync_q[i]) : fade_rd[i];
    end
    rd_data = 8'h00;
    rd_data[WIDTH-1:0] = address[0] ? (ddr_q & MASK_W) : rd_port;
  end

  assign data_out = data_oe ? rd_data : 8'h00;
  assign pio_out  = data_q & MASK_W;
  assign pio_oe   = ddr_q & MASK_W;

endmodule

// File: tb/tb_cpu_pio_port.sv
// Testbench for cpu_pio_port: directed scenarios plus randomized bus traffic,
// compared every cycle against a behavioural model of the port.
module tb_cpu_pio_port;

  localparam logic [7:0] MASK = 8'hDF;
  localparam int         FADE = 16;

  logic        clock = 1'b0;
  logic        _reset = 1'b0;
  logic        aec = 1'b0;
  logic        r_w = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  pio_in = 8'h00;
  logic [7:0]  pio_out;
  logic [7:0]  pio_oe;

  int n_pass  = 0;
  int n_total = 0;

  cpu_pio_port #(
    .WIDTH(8), .IMPL_MASK(MASK), .BASE_ADDR(16'h0000),
    .DATA_RESET(8'h00), .DDR_RESET(8'h00), .FADE_CYCLES(FADE)
  ) dut (
    .clock(clock), ._reset(_reset), .aec(aec), .r_w(r_w),
    .address(address), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe)
  );

  always #5 clock = ~clock;

  // Behavioural model: register contents, recent pin samples, and for each
  // unbonded bit the edge at which it was last driven and the value held then.
  logic [7:0] m_data;
  logic [7:0] m_ddr;
  logic [7:0] pin_hist[$];
  int         ecount;
  int         last_hi[8];
  logic [7:0] m_chg;
  logic [7:0] last_rd;

  function automatic logic [7:0] m_read(input logic a0);
    logic [7:0] r;
    logic [7:0] sync;
    sync = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size()-2] : 8'h00;
    if (a0) return m_ddr & MASK;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (MASK[i]) r[i] = m_ddr[i] ? m_data[i] : sync[i];
      else begin
`ifdef FADE_EN
        r[i] = m_ddr[i] ? m_data[i] : (((ecount - last_hi[i]) < FADE) ? m_chg[i] : 1'b0);
`else
        r[i] = 1'b0;
`endif
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_data = 8'h00;
    m_ddr  = 8'h00;
    pin_hist.delete();
    ecount = 0;
    for (int i = 0; i < 8; i++) last_hi[i] = -1000;
    m_chg = 8'h00;
  endtask

  task automatic model_edge(input logic a, input logic rw, input logic [15:0] addr,
                            input logic [7:0] din, input logic [7:0] pin);
    ecount++;
    for (int i = 0; i < 8; i++) begin
      if (!MASK[i] && m_ddr[i]) begin
        last_hi[i] = ecount;
        m_chg[i]   = m_data[i];
      end
    end
    pin_hist.push_back(pin);
    if (pin_hist.size() > 2) void'(pin_hist.pop_front());
    if (a && addr[15:1] == 15'h0000 && !rw) begin
      if (addr[0]) m_ddr = din;
      else         m_data = din;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One bus cycle, entered and left at 1 time unit after a falling edge.
  task automatic cycle(input logic a, input logic rw, input logic [15:0] addr, input logic [7:0] din);
    logic exp_oe;
    aec = a; r_w = rw; address = addr; data_in = din;
    #2;
    check("low_data_oe", {7'b0, data_oe}, 8'h00);
    check("low_data_out", data_out, 8'h00);
    check("pio_out", pio_out, m_data & MASK);
    check("pio_oe", pio_oe, m_ddr & MASK);
    @(posedge clock); #2;
    exp_oe = a && (addr[15:1] == 15'h0000) && rw;
    check("data_oe", {7'b0, data_oe}, {7'b0, exp_oe});
    check("data_out", data_out, exp_oe ? m_read(addr[0]) : 8'h00);
    last_rd = data_out;
    @(negedge clock);
    model_edge(a, rw, addr, din, pio_in);
    #1;
  endtask

  task automatic fade_run(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, 1'b1, 16'h0000, 8'h00);
      check(name, {7'b0, last_rd[5]}, {7'b0, (k < 16)});
    end
  endtask

  initial begin
    model_reset();
    #2;
    check("rst_pio_oe", pio_oe, 8'h00);
    check("rst_pio_out", pio_out, 8'h00);
    check("rst_data_oe", {7'b0, data_oe}, 8'h00);
    @(negedge clock); #1;
    _reset = 1'b1;

    // Scenario 1: outputs after DDR/data writes.
    cycle(1'b1, 1'b0, 16'h0001, 8'hFF);
    cycle(1'b1, 1'b0, 16'h0000, 8'hA5);
    cycle(1'b1, 1'b1, 16'h0001, 8'h00);
    check("t1_pio_oe", pio_oe, 8'hDF);
    check("t1_pio_out", pio_out, 8'h85);
    check("t1_read_ddr", last_rd, 8'hDF);

    // Scenario 2: synchroniser latency.
    cycle(1'b1, 1'b0, 16'h0001, 8'h0F);
    cycle(1'b1, 1'b0, 16'h0000, 8'h0C);
    pio_in = 8'h3C;
    cycle(1'b1, 1'b1, 16'h0000, 8'h00);
    cycle(1'b1, 1'b1, 16'h0000, 8'h00);
`ifdef FADE_EN
    check("t2_read_1edge", last_rd, 8'h2C);
`else
    check("t2_read_1edge", last_rd, 8'h0C);
`endif
    cycle(1'b1, 1'b1, 16'h0000, 8'h00);
`ifdef FADE_EN
    check("t2_read_2edge", last_rd, 8'h3C);
`else
    check("t2_read_2edge", last_rd, 8'h1C);
`endif

    // Scenario 3: ignored writes.
    cycle(1'b0, 1'b0, 16'h0000, 8'h77);
    cycle(1'b1, 1'b0, 16'h1000, 8'h77);
    cycle(1'b1, 1'b1, 16'h1000, 8'h00);
    check("t3_pio_out", pio_out, 8'h0C);

    // Scenario 4: asynchronous reset in the phi2-high phase.
    cycle(1'b1, 1'b0, 16'h0001, 8'hFF);
    cycle(1'b1, 1'b0, 16'h0000, 8'hA5);
    aec = 1'b1; r_w = 1'b1; address = 16'h0000;
    @(posedge clock); #2;
    _reset = 1'b0;
    model_reset();
    #1;
    check("t4_pio_oe", pio_oe, 8'h00);
    check("t4_pio_out", pio_out, 8'h00);
    check("t4_data_oe", {7'b0, data_oe}, 8'h01);
    check("t4_data_out", data_out, m_read(1'b0));
    @(negedge clock); #1;
    _reset = 1'b1;
    cycle(1'b1, 1'b1, 16'h0000, 8'h00);
    cycle(1'b1, 1'b1, 16'h0000, 8'h00);
    cycle(1'b1, 1'b1, 16'h0000, 8'h00);
    check("t4_read_after", last_rd, 8'h1C);

`ifdef FADE_EN
    // Scenario 5: unbonded bit 5 decays 16 edges after release.
    cycle(1'b1, 1'b0, 16'h0001, 8'hFF);
    cycle(1'b1, 1'b0, 16'h0000, 8'h20);
    cycle(1'b1, 1'b0, 16'h0001, 8'h00);
    fade_run("t5_fade_bit5", 19);

    // Scenario 6: re-driving bit 5 mid-count restarts the decay.
    cycle(1'b1, 1'b0, 16'h0001, 8'hFF);
    cycle(1'b1, 1'b0, 16'h0000, 8'h20);
    cycle(1'b1, 1'b0, 16'h0001, 8'h00);
    for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, 16'h0000, 8'h00);
    cycle(1'b1, 1'b0, 16'h0001, 8'h20);
    cycle(1'b1, 1'b0, 16'h0001, 8'h00);
    fade_run("t6_fade_bit5", 19);
`else
    cycle(1'b1, 1'b0, 16'h0001, 8'hFF);
    cycle(1'b1, 1'b0, 16'h0000, 8'h20);
    cycle(1'b1, 1'b1, 16'h0000, 8'h00);
    check("t5_bit5_absent", {7'b0, last_rd[5]}, 8'h00);
`endif

    // Randomized bus traffic and pin activity.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] addr;
      case ($urandom_range(0, 4))
        0, 1: addr = 16'h0000;
        2:    addr = 16'h0001;
        3:    addr = 16'(16'h0002 + $urandom_range(0, 3));
        default: addr = 16'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) pio_in = 8'($urandom);
      cycle($urandom_range(0, 7) != 0, 1'($urandom), addr, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
